// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS decode-stage register file and its scoreboard.
package regfile_pkg;

    localparam int REGFILE_WIDTH = 32;
    localparam int REGFILE_DEPTH = 32;
    localparam int REGFILE_NREAD = 2;

    // Index of the hardwired zero register.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_sb_busy_tracker.sv
// Per-register busy scoreboard: Issue marks a destination pending, a write-back
// retires it, Flush drops everything. Also produces the decode stall request.
module sb_busy_tracker
    import regfile_pkg::*;
#(
    parameter  int DEPTH = REGFILE_DEPTH,
    parameter  int NREAD = REGFILE_NREAD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREAD*AW-1:0] ra,
    input  logic                le,
    input  logic [AW-1:0]       rw,
    input  logic                issue,
    input  logic [AW-1:0]       issue_reg,
    input  logic                flush,
    output logic                stall,
    output logic [DEPTH-1:0]    busy_vec
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW-1:0]    rd_idx;

    // Next busy vector: flush beats everything; otherwise retire then set, so a newer issue wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (le && (rw != ZERO_IDX)) begin
                busy_d[rw] = 1'b0;
            end
            if (issue && (issue_reg != ZERO_IDX)) begin
                busy_d[issue_reg] = 1'b1;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Scoreboard register; reset discards all pending producers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Stall when a port reads a busy register that is not being written back this cycle.
    always_comb begin
        stall  = 1'b0;
        rd_idx = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_idx = ra[i*AW +: AW];
            if ((rd_idx != ZERO_IDX) && busy_q[rd_idx] && !(le && (rw == rd_idx))) begin
                stall = 1'b1;
            end
        end
        if (rst) begin
            stall = 1'b0;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port MIPS register file with write-to-read bypass, hardwired r0,
// HI/LO special registers and a hazard scoreboard driving the decode stall.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int WIDTH = REGFILE_WIDTH,
    parameter  int DEPTH = REGFILE_DEPTH,
    parameter  int NREAD = REGFILE_NREAD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREAD*AW-1:0]    RA,
    output logic [NREAD*WIDTH-1:0] PA,
    input  logic [WIDTH-1:0]       PW,
    input  logic [AW-1:0]          RW,
    input  logic                   LE,
    input  logic                   Issue,
    input  logic [AW-1:0]          IssueReg,
    input  logic                   Flush,
    output logic                   Stall,
    output logic [DEPTH-1:0]       BusyVec,
    input  logic                   HiLE,
    input  logic                   LoLE,
    input  logic [WIDTH-1:0]       HiW,
    input  logic [WIDTH-1:0]       LoW,
    output logic [WIDTH-1:0]       Hi,
    output logic [WIDTH-1:0]       Lo
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [AW-1:0]    rd_idx;
    logic             wr_en;

    // Writes to r0 are discarded, so they neither commit nor bypass.
    assign wr_en = LE && (RW != ZERO_IDX);

    // Next array and HI/LO contents.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[RW] = PW;
        end
        hi_d = HiLE ? HiW : hi_q;
        lo_d = LoLE ? LoW : lo_q;
    end

    // Storage; reset clears the array and HI/LO regardless of any write in that cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            regs_q <= regs_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Combinational read ports: r0 reads zero, a same-cycle write is forwarded, reset forces zero.
    always_comb begin
        PA     = '0;
        rd_idx = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_idx = RA[i*AW +: AW];
            if (!Reset && (rd_idx != ZERO_IDX)) begin
                PA[i*WIDTH +: WIDTH] = (wr_en && (RW == rd_idx)) ? PW : regs_q[rd_idx];
            end
        end
    end

    assign Hi = hi_q;
    assign Lo = lo_q;

    sb_busy_tracker #(
        .DEPTH(DEPTH),
        .NREAD(NREAD)
    ) u_busy (
        .clk      (Clk),
        .rst      (Reset),
        .ra       (RA),
        .le       (LE),
        .rw       (RW),
        .issue    (Issue),
        .issue_reg(IssueReg),
        .flush    (Flush),
        .stall    (Stall),
        .busy_vec (BusyVec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: the driver computes expected outputs from a
// behavioural model and queues them; a monitor pops and compares mid-cycle.
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = $clog2(DEPTH);

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic [NREAD*AW-1:0]    RA;
    logic [NREAD*WIDTH-1:0] PA;
    logic [WIDTH-1:0]       PW;
    logic [AW-1:0]          RW;
    logic                   LE;
    logic                   Issue;
    logic [AW-1:0]          IssueReg;
    logic                   Flush;
    logic                   Stall;
    logic [DEPTH-1:0]       BusyVec;
    logic                   HiLE, LoLE;
    logic [WIDTH-1:0]       HiW, LoW;
    logic [WIDTH-1:0]       Hi, Lo;

    always #5 Clk = ~Clk;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .PA(PA), .PW(PW), .RW(RW), .LE(LE),
        .Issue(Issue), .IssueReg(IssueReg), .Flush(Flush), .Stall(Stall),
        .BusyVec(BusyVec), .HiLE(HiLE), .LoLE(LoLE), .HiW(HiW), .LoW(LoW),
        .Hi(Hi), .Lo(Lo)
    );

    typedef struct {
        logic [NREAD*WIDTH-1:0] pa;
        logic                   stall;
        logic [DEPTH-1:0]       busy;
        logic [WIDTH-1:0]       hi;
        logic [WIDTH-1:0]       lo;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    logic [WIDTH-1:0] m_reg [DEPTH];
    bit               m_busy [DEPTH];
    logic [WIDTH-1:0] m_hi, m_lo;

    int checks = 0;
    int errors = 0;

    function automatic logic [WIDTH-1:0] ref_read(int a);
        if (a == 0) return '0;
        if (LE && (int'(RW) == a)) return PW;
        return m_reg[a];
    endfunction

    // Queue expected outputs for the current inputs, then advance the model across the edge.
    task automatic cycle(input bit chk);
        exp_t e;
        int   a;
        if (chk) begin
            e.pa    = '0;
            e.stall = 1'b0;
            for (int p = 0; p < NREAD; p++) begin
                a = int'(RA[p*AW +: AW]);
                if (!Reset) begin
                    e.pa[p*WIDTH +: WIDTH] = ref_read(a);
                    if (a != 0 && m_busy[a] && !(LE && int'(RW) == a)) e.stall = 1'b1;
                end
            end
            for (int r = 0; r < DEPTH; r++) e.busy[r] = m_busy[r];
            e.hi = m_hi;
            e.lo = m_lo;
            exp_q.push_back(e);
        end
        @(posedge Clk);
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_reg[r]  = '0;
                m_busy[r] = 1'b0;
            end
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (LE && RW != 0) m_reg[RW] = PW;
            if (HiLE) m_hi = HiW;
            if (LoLE) m_lo = LoW;
            if (Flush) begin
                for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
            end else begin
                if (LE && RW != 0) m_busy[RW] = 1'b0;
                if (Issue && IssueReg != 0) m_busy[IssueReg] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        Reset = 1'b0; LE = 1'b0; RW = '0; PW = '0; Issue = 1'b0; IssueReg = '0;
        Flush = 1'b0; HiLE = 1'b0; LoLE = 1'b0; HiW = '0; LoW = '0; RA = '0;
    endtask

    task automatic set_ra(input int p0, input int p1);
        RA[0*AW +: AW] = AW'(p0);
        RA[1*AW +: AW] = AW'(p1);
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle, mid-cycle, away from the active edge.
    always @(negedge Clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < NREAD; p++) begin
                cmp($sformatf("pa%0d", p), 64'(PA[p*WIDTH +: WIDTH]), 64'(e.pa[p*WIDTH +: WIDTH]));
            end
            cmp("stall", 64'(Stall), 64'(e.stall));
            cmp("busyvec", 64'(BusyVec), 64'(e.busy));
            cmp("hi", 64'(Hi), 64'(e.hi));
            cmp("lo", 64'(Lo), 64'(e.lo));
        end
    end

    initial begin
        for (int r = 0; r < DEPTH; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_hi = '0;
        m_lo = '0;

        // Reset for two cycles while a write and HI/LO loads are requested
        idle();
        Reset = 1'b1; LE = 1'b1; RW = 5'd3; PW = 32'hFFFF_FFFF;
        HiLE = 1'b1; LoLE = 1'b1; HiW = 32'h1; LoW = 32'h2; Issue = 1'b1; IssueReg = 5'd3;
        set_ra(3, 0);
        #1;
        cycle(0);
        cycle(1);
        idle(); set_ra(3, 0); cycle(1);

        // Zero register
        idle(); LE = 1'b1; RW = 5'd0; PW = 32'h1234; set_ra(0, 0); cycle(1);
        idle(); set_ra(0, 0); cycle(1);
        idle(); LE = 1'b1; RW = 5'd7; PW = 32'hDEAD_BEEF; set_ra(7, 0); cycle(1);
        idle(); set_ra(7, 0); cycle(1);

        // Scoreboard hazard on r9
        idle(); Issue = 1'b1; IssueReg = 5'd9; cycle(1);
        idle(); set_ra(0, 9); cycle(1);
        idle(); set_ra(0, 9); cycle(1);
        idle(); LE = 1'b1; RW = 5'd9; PW = 32'h55; set_ra(0, 9); cycle(1);
        idle(); set_ra(0, 9); cycle(1);

        // Simultaneous issue and retire on r4
        idle(); Issue = 1'b1; IssueReg = 5'd4; LE = 1'b1; RW = 5'd4; PW = 32'h44; cycle(1);
        idle(); set_ra(4, 0); cycle(1);
        idle(); Issue = 1'b1; IssueReg = 5'd0; set_ra(0, 0); cycle(1);

        // Flush with a same-cycle issue
        idle(); Issue = 1'b1; IssueReg = 5'd2; cycle(1);
        idle(); Issue = 1'b1; IssueReg = 5'd3; cycle(1);
        idle(); Flush = 1'b1; Issue = 1'b1; IssueReg = 5'd6; LE = 1'b1; RW = 5'd11; PW = 32'hCAFE;
        set_ra(2, 3); cycle(1);
        idle(); set_ra(6, 11); cycle(1);

        // HI/LO
        idle(); HiLE = 1'b1; LoLE = 1'b1; HiW = 32'hA; LoW = 32'hB; cycle(1);
        idle(); cycle(1);
        idle(); HiLE = 1'b1; HiW = 32'hC; cycle(1);
        idle(); cycle(1);

        // Randomized traffic; small index range concentrates hazards
        for (int n = 0; n < 500; n++) begin
            idle();
            Reset    = ($urandom_range(0, 63) == 0);
            Flush    = ($urandom_range(0, 15) == 0);
            LE       = $urandom_range(0, 1);
            RW       = AW'($urandom_range(0, 7));
            PW       = $urandom;
            Issue    = ($urandom_range(0, 2) == 0);
            IssueReg = AW'($urandom_range(0, 7));
            HiLE     = $urandom_range(0, 1);
            LoLE     = $urandom_range(0, 1);
            HiW      = $urandom;
            LoW      = $urandom;
            if ($urandom_range(0, 7) == 0) set_ra($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            else set_ra($urandom_range(0, 7), $urandom_range(0, 7));
            cycle(1);
        end

        // Drain the scoreboard with a bounded wait
        idle();
        for (int k = 0; k < 4; k++) cycle(0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
